// File: rtl/tcp_pkg.sv
// tcp_pkg: shared sizing constants for the TCP receive path.
//   MAX_TCP_FLOWS     - number of concurrently tracked flows (power of 2)
//   RX_PAYLOAD_PTR_W  - byte-address width of the RX payload buffer; stored
//                       pointers carry one extra wrap bit above this width
//   ST_INIT / ST_RUN  - state encoding of the pointer-table sweep FSM
package tcp_pkg;

  localparam int MAX_TCP_FLOWS    = 16;
  localparam int RX_PAYLOAD_PTR_W = 14;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/rx_ptr_bank.sv
// rx_ptr_bank: one-write / one-read flop array holding one pointer per flow.
// The read port is combinational with write-first bypass: when the write
// and read hit the same entry in the same cycle, rd_data returns wr_data.
// Ports:
//   clk      - clock, write on rising edge
//   wr_en    - write strobe
//   wr_addr  - entry written
//   wr_data  - value written
//   rd_addr  - entry read
//   rd_data  - entry value (bypassed from the write port on an address hit)
module rx_ptr_bank #(
  parameter int DEPTH = 8,
  parameter int W     = 5,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  // No reset: the owning table sweeps every entry to zero after reset.
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
    else                               rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/rx_buf_ptr_table.sv
// rx_buf_ptr_table: per-flow head / commit / tail pointer table for the RX
// payload buffer, with a combined lookup that also returns used and
// available byte counts.
// Ports:
//   clk, rst              - clock; synchronous active-high reset
//   new_flow_*            - flow initialisation (head, commit := tail ptr);
//                           has absolute priority over single-pointer writes
//   head_wr_* / commit_wr_* / tail_wr_*
//                         - independent single-pointer updates
//   rd_req_*              - lookup request
//   rd_resp_*             - registered lookup response (snapshot + used/avail)
//   dbg_state             - current FSM state (ST_INIT / ST_RUN)
// Handshake: a transfer happens on a rising edge where val=1 and rdy=1;
// rdy never depends on the same interface's val, and rd_resp_* hold still
// while rd_resp_val=1 and rd_resp_rdy=0.
// After reset the table spends NUM_FLOWS_P cycles in ST_INIT zeroing every
// entry; all rdy outputs are low during that sweep.
module rx_buf_ptr_table
  import tcp_pkg::*;
#(
  parameter int NUM_FLOWS_P = MAX_TCP_FLOWS,
  parameter int PTR_W_P     = RX_PAYLOAD_PTR_W,
  localparam int FID_W      = $clog2(NUM_FLOWS_P),
  localparam int PW         = PTR_W_P + 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             new_flow_val,
  input  logic [FID_W-1:0] new_flow_flowid,
  input  logic [PW-1:0]    new_flow_head_ptr,
  input  logic [PW-1:0]    new_flow_tail_ptr,
  output logic             new_flow_rdy,

  input  logic             head_wr_val,
  input  logic [FID_W-1:0] head_wr_addr,
  input  logic [PW-1:0]    head_wr_data,
  output logic             head_wr_rdy,

  input  logic             commit_wr_val,
  input  logic [FID_W-1:0] commit_wr_addr,
  input  logic [PW-1:0]    commit_wr_data,
  output logic             commit_wr_rdy,

  input  logic             tail_wr_val,
  input  logic [FID_W-1:0] tail_wr_addr,
  input  logic [PW-1:0]    tail_wr_data,
  output logic             tail_wr_rdy,

  input  logic             rd_req_val,
  input  logic [FID_W-1:0] rd_req_addr,
  output logic             rd_req_rdy,

  output logic             rd_resp_val,
  output logic [PW-1:0]    rd_resp_head,
  output logic [PW-1:0]    rd_resp_commit,
  output logic [PW-1:0]    rd_resp_tail,
  output logic [PW-1:0]    rd_resp_used,
  output logic [PW-1:0]    rd_resp_avail,
  input  logic             rd_resp_rdy,

  output logic [0:0]       dbg_state
);

  // Full buffer size in bytes, expressed in pointer width.
  localparam logic [PW-1:0] BUF_BYTES = {1'b1, {PTR_W_P{1'b0}}};
  localparam logic [FID_W-1:0] LAST_FID = FID_W'(NUM_FLOWS_P - 1);

  logic [0:0]       state_q, state_d;
  logic [FID_W-1:0] cnt_q, cnt_d;
  logic             run;

  logic             resp_val_q, resp_val_d;
  logic [PW-1:0]    resp_head_q, resp_head_d;
  logic [PW-1:0]    resp_commit_q, resp_commit_d;
  logic [PW-1:0]    resp_tail_q, resp_tail_d;
  logic [PW-1:0]    resp_used_q, resp_used_d;
  logic [PW-1:0]    resp_avail_q, resp_avail_d;

  logic             h_we, c_we, t_we;
  logic [FID_W-1:0] h_wa, c_wa, t_wa;
  logic [PW-1:0]    h_wd, c_wd, t_wd;
  logic [PW-1:0]    h_rd, c_rd, t_rd;
  logic             rd_accept;

  assign run = (state_q == ST_RUN);

  // Ready generation.
  always_comb begin
    new_flow_rdy  = run;
    head_wr_rdy   = run & ~new_flow_val;
    commit_wr_rdy = run & ~new_flow_val;
    tail_wr_rdy   = run & ~new_flow_val;
    rd_req_rdy    = run & (~resp_val_q | rd_resp_rdy);
  end

  assign rd_accept = rd_req_val & rd_req_rdy;

  // Sweep FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_FID) state_d = ST_RUN;
    end
  end

  // Bank write arbitration: sweep zeroing, then flow init, then the
  // independent single-pointer writes.
  always_comb begin
    h_we = 1'b0;  h_wa = '0;  h_wd = '0;
    c_we = 1'b0;  c_wa = '0;  c_wd = '0;
    t_we = 1'b0;  t_wa = '0;  t_wd = '0;
    if (!run) begin
      h_we = 1'b1;  h_wa = cnt_q;
      c_we = 1'b1;  c_wa = cnt_q;
      t_we = 1'b1;  t_wa = cnt_q;
    end else if (new_flow_val) begin
      h_we = 1'b1;  h_wa = new_flow_flowid;  h_wd = new_flow_head_ptr;
      c_we = 1'b1;  c_wa = new_flow_flowid;  c_wd = new_flow_tail_ptr;
      t_we = 1'b1;  t_wa = new_flow_flowid;  t_wd = new_flow_tail_ptr;
    end else begin
      h_we = head_wr_val;    h_wa = head_wr_addr;    h_wd = head_wr_data;
      c_we = commit_wr_val;  c_wa = commit_wr_addr;  c_wd = commit_wr_data;
      t_we = tail_wr_val;    t_wa = tail_wr_addr;    t_wd = tail_wr_data;
    end
  end

  rx_ptr_bank #(.DEPTH(NUM_FLOWS_P), .W(PW)) u_head_bank (
    .clk(clk), .wr_en(h_we), .wr_addr(h_wa), .wr_data(h_wd),
    .rd_addr(rd_req_addr), .rd_data(h_rd)
  );

  rx_ptr_bank #(.DEPTH(NUM_FLOWS_P), .W(PW)) u_commit_bank (
    .clk(clk), .wr_en(c_we), .wr_addr(c_wa), .wr_data(c_wd),
    .rd_addr(rd_req_addr), .rd_data(c_rd)
  );

  rx_ptr_bank #(.DEPTH(NUM_FLOWS_P), .W(PW)) u_tail_bank (
    .clk(clk), .wr_en(t_we), .wr_addr(t_wa), .wr_data(t_wd),
    .rd_addr(rd_req_addr), .rd_data(t_rd)
  );

  // Response register: snapshot at acceptance, including same-cycle
  // writes via the bank bypass. used/avail are registered with the
  // snapshot so the whole response resets to zero. Arithmetic wraps
  // naturally at PW bits.
  always_comb begin
    resp_val_d    = resp_val_q;
    resp_head_d   = resp_head_q;
    resp_commit_d = resp_commit_q;
    resp_tail_d   = resp_tail_q;
    resp_used_d   = resp_used_q;
    resp_avail_d  = resp_avail_q;
    if (rd_accept) begin
      resp_val_d    = 1'b1;
      resp_head_d   = h_rd;
      resp_commit_d = c_rd;
      resp_tail_d   = t_rd;
      resp_used_d   = t_rd - h_rd;
      resp_avail_d  = BUF_BYTES - (t_rd - h_rd);
    end else if (rd_resp_rdy) begin
      resp_val_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      resp_val_q    <= 1'b0;
      resp_head_q   <= '0;
      resp_commit_q <= '0;
      resp_tail_q   <= '0;
      resp_used_q   <= '0;
      resp_avail_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      resp_val_q    <= resp_val_d;
      resp_head_q   <= resp_head_d;
      resp_commit_q <= resp_commit_d;
      resp_tail_q   <= resp_tail_d;
      resp_used_q   <= resp_used_d;
      resp_avail_q  <= resp_avail_d;
    end
  end

  assign rd_resp_val    = resp_val_q;
  assign rd_resp_head   = resp_head_q;
  assign rd_resp_commit = resp_commit_q;
  assign rd_resp_tail   = resp_tail_q;
  assign rd_resp_used   = resp_used_q;
  assign rd_resp_avail  = resp_avail_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_rx_buf_ptr_table.sv
// Bench for rx_buf_ptr_table with 8 flows and 4-bit buffer addresses
// (5-bit stored pointers, buffer size 16).
module tb_rx_buf_ptr_table;

  localparam int NF  = 8;
  localparam int PTW = 4;
  localparam int PW  = PTW + 1;
  localparam int FW  = 3;
  localparam int BUF = 16;
  localparam int MOD = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          new_flow_val, new_flow_rdy;
  logic [FW-1:0] new_flow_flowid;
  logic [PW-1:0] new_flow_head_ptr, new_flow_tail_ptr;
  logic          head_wr_val, head_wr_rdy, commit_wr_val, commit_wr_rdy, tail_wr_val, tail_wr_rdy;
  logic [FW-1:0] head_wr_addr, commit_wr_addr, tail_wr_addr;
  logic [PW-1:0] head_wr_data, commit_wr_data, tail_wr_data;
  logic          rd_req_val, rd_req_rdy;
  logic [FW-1:0] rd_req_addr;
  logic          rd_resp_val, rd_resp_rdy;
  logic [PW-1:0] rd_resp_head, rd_resp_commit, rd_resp_tail, rd_resp_used, rd_resp_avail;
  logic [0:0]    dbg_state;

  rx_buf_ptr_table #(.NUM_FLOWS_P(NF), .PTR_W_P(PTW)) dut (
    .clk(clk), .rst(rst),
    .new_flow_val(new_flow_val), .new_flow_flowid(new_flow_flowid),
    .new_flow_head_ptr(new_flow_head_ptr), .new_flow_tail_ptr(new_flow_tail_ptr),
    .new_flow_rdy(new_flow_rdy),
    .head_wr_val(head_wr_val), .head_wr_addr(head_wr_addr), .head_wr_data(head_wr_data),
    .head_wr_rdy(head_wr_rdy),
    .commit_wr_val(commit_wr_val), .commit_wr_addr(commit_wr_addr), .commit_wr_data(commit_wr_data),
    .commit_wr_rdy(commit_wr_rdy),
    .tail_wr_val(tail_wr_val), .tail_wr_addr(tail_wr_addr), .tail_wr_data(tail_wr_data),
    .tail_wr_rdy(tail_wr_rdy),
    .rd_req_val(rd_req_val), .rd_req_addr(rd_req_addr), .rd_req_rdy(rd_req_rdy),
    .rd_resp_val(rd_resp_val), .rd_resp_head(rd_resp_head), .rd_resp_commit(rd_resp_commit),
    .rd_resp_tail(rd_resp_tail), .rd_resp_used(rd_resp_used), .rd_resp_avail(rd_resp_avail),
    .rd_resp_rdy(rd_resp_rdy),
    .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic nf_v; int nf_id, nf_h, nf_t;
    logic h_v;  int h_a, h_d;
    logic c_v;  int c_a, c_d;
    logic t_v;  int t_a, t_d;
    logic rd_same; int rd_a;
    logic e_hrdy;
    int e_h, e_c, e_t, e_u, e_a;
  } vec_t;

  vec_t vecs[7];

  // Reference model: pointer arrays plus a queue of expected responses,
  // each packed as {head, commit, tail, used, avail}.
  int mh[NF], mc[NF], mt[NF];
  logic [5*PW-1:0] exp_q[$];

  function automatic logic [5*PW-1:0] make_resp(input int h, input int c, input int t);
    int used, avail;
    used  = (t + MOD - h) % MOD;
    avail = (BUF + MOD - used) % MOD;
    return {PW'(h), PW'(c), PW'(t), PW'(used), PW'(avail)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_resp(input string name, input int h, input int c, input int t,
                          input int u, input int a);
    check({name, " val"},    32'(rd_resp_val), 1);
    check({name, " head"},   32'(rd_resp_head), h);
    check({name, " commit"}, 32'(rd_resp_commit), c);
    check({name, " tail"},   32'(rd_resp_tail), t);
    check({name, " used"},   32'(rd_resp_used), u);
    check({name, " avail"},  32'(rd_resp_avail), a);
  endtask

  task automatic drive_idle();
    new_flow_val = 0; new_flow_flowid = '0; new_flow_head_ptr = '0; new_flow_tail_ptr = '0;
    head_wr_val = 0; head_wr_addr = '0; head_wr_data = '0;
    commit_wr_val = 0; commit_wr_addr = '0; commit_wr_data = '0;
    tail_wr_val = 0; tail_wr_addr = '0; tail_wr_data = '0;
    rd_req_val = 0; rd_req_addr = '0;
    rd_resp_rdy = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] all_rdy();
    return {new_flow_rdy, head_wr_rdy, commit_wr_rdy, tail_wr_rdy, rd_req_rdy};
  endfunction

  // Called at the negedge where rst has just been released.
  task automatic check_sweep(input string name);
    for (int i = 0; i < NF; i++) begin
      #1 check({name, " rdy low during sweep"}, 32'(all_rdy()), 0);
      next_cycle();
    end
    #1 check({name, " rdy high after sweep"}, 32'(all_rdy()), 32'h1f);
  endtask

  task automatic do_read(input string name, input int a, input int h, input int c,
                         input int t, input int u, input int av);
    rd_req_val = 1; rd_req_addr = FW'(a);
    next_cycle();
    rd_req_val = 0;
    chk_resp(name, h, c, t, u, av);
  endtask

  initial begin
    drive_idle();
    rst = 1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("reset rdy", 32'(all_rdy()), 0);
    check("reset resp_val", 32'(rd_resp_val), 0);
    check("reset resp data", 32'({rd_resp_head, rd_resp_commit, rd_resp_tail, rd_resp_used, rd_resp_avail}), 0);
    rst = 0;
    check_sweep("init");
    do_read("read flow3 after init", 3, 0, 0, 0, 0, 16);

    // Table-driven write/read vectors.
    vecs[0] = '{1, 2, 5, 5,   1, 2, 9,   0, 0, 0,   0, 0, 0,   0, 2, 0,  5, 5, 5, 0, 16};
    vecs[1] = '{0, 0, 0, 0,   0, 0, 0,   0, 0, 0,   1, 2, 19,  0, 2, 1,  5, 5, 19, 14, 2};
    vecs[2] = '{0, 0, 0, 0,   0, 0, 0,   0, 0, 0,   1, 4, 7,   1, 4, 1,  0, 0, 7, 7, 9};
    vecs[3] = '{0, 0, 0, 0,   1, 6, 3,   1, 6, 10,  1, 6, 12,  1, 6, 1,  3, 10, 12, 9, 7};
    vecs[4] = '{1, 1, 30, 2,  0, 0, 0,   1, 1, 9,   0, 0, 0,   0, 1, 0,  30, 2, 2, 4, 12};
    vecs[5] = '{0, 0, 0, 0,   1, 4, 7,   0, 0, 0,   0, 0, 0,   0, 4, 1,  7, 0, 7, 0, 16};
    vecs[6] = '{0, 0, 0, 0,   1, 5, 0,   0, 0, 0,   1, 5, 16,  1, 5, 1,  0, 0, 16, 16, 0};

    for (int v = 0; v < 7; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      new_flow_val = vecs[v].nf_v; new_flow_flowid = FW'(vecs[v].nf_id);
      new_flow_head_ptr = PW'(vecs[v].nf_h); new_flow_tail_ptr = PW'(vecs[v].nf_t);
      head_wr_val = vecs[v].h_v; head_wr_addr = FW'(vecs[v].h_a); head_wr_data = PW'(vecs[v].h_d);
      commit_wr_val = vecs[v].c_v; commit_wr_addr = FW'(vecs[v].c_a); commit_wr_data = PW'(vecs[v].c_d);
      tail_wr_val = vecs[v].t_v; tail_wr_addr = FW'(vecs[v].t_a); tail_wr_data = PW'(vecs[v].t_d);
      rd_req_val = vecs[v].rd_same; rd_req_addr = FW'(vecs[v].rd_a);
      #1 check({nm, " head_wr_rdy"}, 32'(head_wr_rdy), 32'(vecs[v].e_hrdy));
      check({nm, " tail_wr_rdy"}, 32'(tail_wr_rdy), 32'(vecs[v].e_hrdy));
      next_cycle();
      drive_idle();
      if (!vecs[v].rd_same) begin
        rd_req_val = 1; rd_req_addr = FW'(vecs[v].rd_a);
        next_cycle();
        drive_idle();
      end
      chk_resp(nm, vecs[v].e_h, vecs[v].e_c, vecs[v].e_t, vecs[v].e_u, vecs[v].e_a);
    end

    // Stall: response held 3 cycles while flow 6's head is rewritten.
    next_cycle();
    rd_resp_rdy = 0; rd_req_val = 1; rd_req_addr = 3'd6;
    next_cycle();
    head_wr_val = 1; head_wr_addr = 3'd6; head_wr_data = 5'd1;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall rd_req_rdy", 32'(rd_req_rdy), 0);
      chk_resp("stall hold", 3, 10, 12, 9, 7);
      next_cycle();
      head_wr_val = 0;
    end
    rd_resp_rdy = 1;
    #1 check("stall release rd_req_rdy", 32'(rd_req_rdy), 1);
    next_cycle();
    rd_req_val = 0;
    chk_resp("back-to-back after stall", 1, 10, 12, 11, 5);
    next_cycle();
    check("resp_val clears", 32'(rd_resp_val), 0);

    // Reset with a response in flight and a request pending.
    rd_resp_rdy = 0; rd_req_val = 1; rd_req_addr = 3'd2;
    next_cycle();
    chk_resp("pre-reset resp", 5, 5, 19, 14, 2);
    rst = 1;
    next_cycle();
    check("mid reset resp_val", 32'(rd_resp_val), 0);
    check("mid reset resp data", 32'({rd_resp_head, rd_resp_commit, rd_resp_tail, rd_resp_used, rd_resp_avail}), 0);
    rst = 0;
    drive_idle();
    check_sweep("re-init");
    do_read("flow2 after re-init", 2, 0, 0, 0, 0, 16);
    do_read("flow6 after re-init", 6, 0, 0, 0, 0, 16);
    next_cycle();

    // Randomized traffic against the model; table is all zero here.
    for (int i = 0; i < NF; i++) begin
      mh[i] = 0; mc[i] = 0; mt[i] = 0;
    end
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic pending, e_rrdy, accept;
      new_flow_val = ($urandom_range(0, 5) == 0);
      new_flow_flowid = FW'($urandom_range(0, NF - 1));
      new_flow_head_ptr = PW'($urandom_range(0, MOD - 1));
      new_flow_tail_ptr = PW'($urandom_range(0, MOD - 1));
      head_wr_val = ($urandom_range(0, 2) == 0);
      head_wr_addr = FW'($urandom_range(0, NF - 1));
      head_wr_data = PW'($urandom_range(0, MOD - 1));
      commit_wr_val = ($urandom_range(0, 2) == 0);
      commit_wr_addr = FW'($urandom_range(0, NF - 1));
      commit_wr_data = PW'($urandom_range(0, MOD - 1));
      tail_wr_val = ($urandom_range(0, 2) == 0);
      tail_wr_addr = FW'($urandom_range(0, NF - 1));
      tail_wr_data = PW'($urandom_range(0, MOD - 1));
      rd_req_val = ($urandom_range(0, 1) == 1);
      rd_req_addr = FW'($urandom_range(0, NF - 1));
      rd_resp_rdy = ($urandom_range(0, 9) < 7);
      #1;
      pending = (exp_q.size() != 0);
      e_rrdy = !pending || rd_resp_rdy;
      check("rand rdy", 32'(all_rdy()), 32'({1'b1, !new_flow_val, !new_flow_val, !new_flow_val, e_rrdy}));
      check("rand resp_val", 32'(rd_resp_val), 32'(pending));
      if (pending)
        check("rand resp data", 32'({rd_resp_head, rd_resp_commit, rd_resp_tail, rd_resp_used, rd_resp_avail}), 32'(exp_q[0]));
      if (new_flow_val) begin
        mh[new_flow_flowid] = int'(new_flow_head_ptr);
        mc[new_flow_flowid] = int'(new_flow_tail_ptr);
        mt[new_flow_flowid] = int'(new_flow_tail_ptr);
      end else begin
        if (head_wr_val)   mh[head_wr_addr]   = int'(head_wr_data);
        if (commit_wr_val) mc[commit_wr_addr] = int'(commit_wr_data);
        if (tail_wr_val)   mt[tail_wr_addr]   = int'(tail_wr_data);
      end
      accept = rd_req_val && e_rrdy;
      if (pending && rd_resp_rdy) void'(exp_q.pop_front());
      if (accept) exp_q.push_back(make_resp(mh[rd_req_addr], mc[rd_req_addr], mt[rd_req_addr]));
      next_cycle();
    end
    drive_idle();
    #1 check("rand final resp_val", 32'(rd_resp_val), 32'(exp_q.size() != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_buf_ptr_table.md
RX_BUF_PTR_TABLE -- requirements
Module: rx_buf_ptr_table

Interface
REQ-001 SHALL have parameter NUM_FLOWS_P, default MAX_TCP_FLOWS, meaning the number of flow entries (power of 2, at least 2).
REQ-002 SHALL have parameter PTR_W_P, default RX_PAYLOAD_PTR_W, meaning the buffer byte-address width; stored pointers are PTR_W_P+1 bits (MSB = wrap bit).
REQ-003 SHALL derive localparam FID_W = $clog2(NUM_FLOWS_P).
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have ports new_flow_val (in, 1), new_flow_flowid (in, FID_W), new_flow_head_ptr (in, PTR_W_P+1), new_flow_tail_ptr (in, PTR_W_P+1) and new_flow_rdy (out, 1): flow-initialisation write.
REQ-007 SHALL provide, for X in {head, commit, tail}, ports X_wr_val (in, 1), X_wr_addr (in, FID_W), X_wr_data (in, PTR_W_P+1) and X_wr_rdy (out, 1): single-pointer update.
REQ-008 SHALL have ports rd_req_val (in, 1), rd_req_addr (in, FID_W) and rd_req_rdy (out, 1): combined lookup request.
REQ-009 SHALL have ports rd_resp_val (out, 1), rd_resp_head, rd_resp_commit and rd_resp_tail (out, PTR_W_P+1 each), rd_resp_used and rd_resp_avail (out, PTR_W_P+1 each), and rd_resp_rdy (in, 1).

Function
REQ-010 SHALL use a two-state FSM, INIT and RUN; reset enters INIT with sweep counter = 0.
REQ-011 SHALL, in INIT, write 0 to head, commit and tail of entry [counter] each cycle and increment the counter; after entry NUM_FLOWS_P-1 it SHALL enter RUN (NUM_FLOWS_P cycles in total).
REQ-012 SHALL hold every *_rdy output at 0 while in INIT.
REQ-013 SHALL, in RUN, drive new_flow_rdy = 1 and accept a new_flow write whenever it is valid; it writes head = new_flow_head_ptr, and both commit and tail = new_flow_tail_ptr.
REQ-014 SHALL drive X_wr_rdy = RUN & ~new_flow_val, so that flow init has absolute priority over single-pointer writes.
REQ-015 SHALL accept the head, commit and tail writes independently in the same cycle, including writes to the same flow.
REQ-016 SHALL drive rd_req_rdy = RUN & (~rd_resp_val | rd_resp_rdy).
REQ-017 SHALL register a response one cycle after the request is accepted, and rd_resp_val SHALL rise on that cycle.
REQ-018 SHALL use write-first bypass: a write accepted in the same cycle as a read of the same flow appears in that response.
REQ-019 SHALL hold all rd_resp_* fields stable while rd_resp_val=1 and rd_resp_rdy=0, ignoring later writes (snapshot at acceptance).
REQ-020 SHALL clear rd_resp_val when rd_resp_rdy=1 and no new request is accepted in that cycle.
REQ-021 SHALL support back-to-back requests, one accepted per cycle when rd_resp_rdy=1.
REQ-022 SHALL compute rd_resp_used = (tail - head) mod 2^(PTR_W_P+1) from the snapshot values.
REQ-023 SHALL compute rd_resp_avail = 2^PTR_W_P - rd_resp_used, truncated to PTR_W_P+1 bits; there is no saturation, and the caller guarantees used <= 2^PTR_W_P.
REQ-024 SHALL let pointer wrap come only from caller data; the block SHALL NOT alter pointer values.

Reset
REQ-025 SHALL, on rst=1, set state = INIT, counter = 0, rd_resp_val = 0 and all rd_resp data = 0, regardless of activity in progress.
REQ-026 SHALL drop an in-flight response and discard a pending request when rst is asserted mid-operation.

Structure
REQ-027 SHALL keep defaults MAX_TCP_FLOWS and RX_PAYLOAD_PTR_W in tcp_pkg, with no new typedefs needed.
REQ-028 SHALL instantiate three copies of the sub-module rx_ptr_bank, a 1-write/1-read synchronous flop array with write-first bypass, for head, commit and tail.
REQ-029 SHALL contain the FSM, arbitration, response register and arithmetic in rx_buf_ptr_table itself.

Verification (NUM_FLOWS_P=8, PTR_W_P=4)
REQ-030 SHALL cover: release rst -> all rdy = 0 for exactly 8 cycles, then a read of flow 3 returns head/commit/tail = 0, used = 0, avail = 16.
REQ-031 SHALL cover: new_flow flow 2 (head = 5, tail = 5) together with head_wr flow 2 data 9 -> head_wr_rdy = 0; a read of flow 2 then returns 5/5/5, used = 0, avail = 16.
REQ-032 SHALL cover: tail_wr flow 2 data 5'b1_0011 -> a read returns used = 14, avail = 2 (wrap case).
REQ-033 SHALL cover: tail_wr flow 4 data 7 in the same cycle as a read of flow 4 -> the response carries tail = 7.
REQ-034 SHALL cover: rd_resp_rdy held low 3 cycles with a head_wr to the same flow during the stall -> data is unchanged and rd_req_rdy = 0 for those cycles.
REQ-035 SHALL cover: rst pulsed while rd_resp_val = 1 -> rd_resp_val = 0 next cycle, and the 8-cycle sweep reruns with the table re-zeroed.
